mem_access_unit: RTL and testbench

//   Load/store stage directly downstream of the ALU. Takes the ALU result as the effective address and rs2 as store data.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: one req/ack data-bus transaction per accepted request.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata_out,
   output logic        fault,
   output logic        misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   typedef enum logic [1:0] {IDLE, BUS, RESP, DONE} state_t;

   localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    f3_q, f3_n;
   logic [1:0]    lane_q, lane_n;
   logic          req_n, we_n, flt_n, mis_n;
   logic [31:0]   addr_n, wd_n, rd_n;
   logic [3:0]    be_n;
   logic          is_st, illegal, mis, hit_to;
   logic [3:0]    st_be;
   logic [31:0]   st_wd, ext, shifted;
   logic [15:0]   half;

   assign is_st   = !mem_read && mem_write;
   assign illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                 || (is_st && funct3[2]);

`ifdef MISALIGN_TRAP_EN
   assign mis = !illegal
             && (((funct3[1:0] == 2'b01) && addr[0])
             ||  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   assign hit_to = (BUS_TIMEOUT != 0) && (cnt == CW'(BUS_TIMEOUT - 1));

   always_comb begin
      st_be = 4'b1111;
      st_wd = wdata;
      unique case (1'b1)
         funct3[1:0] == 2'b00: begin
            st_be = 4'b0001 << addr[1:0];
            st_wd = {4{wdata[7:0]}};
         end
         funct3[1:0] == 2'b01: begin
            st_be = addr[1] ? 4'b1100 : 4'b0011;
            st_wd = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // lane pick from the captured low address bits
   assign shifted = bus_rdata >> {lane_q, 3'b000};
   assign half    = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      ext = bus_rdata;
      unique case (1'b1)
         f3_q == 3'b000: ext = {{24{shifted[7]}}, shifted[7:0]};
         f3_q == 3'b100: ext = {24'h0, shifted[7:0]};
         f3_q == 3'b001: ext = {{16{half[15]}}, half};
         f3_q == 3'b101: ext = {16'h0, half};
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      f3_n    = f3_q;
      lane_n  = lane_q;
      req_n   = bus_req;
      we_n    = bus_we;
      addr_n  = bus_addr;
      be_n    = bus_be;
      wd_n    = bus_wdata;
      rd_n    = rdata_out;
      flt_n   = fault;
      mis_n   = misalign;
      unique case (state)
         IDLE: begin
            if (start && (mem_read || mem_write)) begin
               we_n   = is_st;
               addr_n = {addr[31:2], 2'b00};
               be_n   = is_st ? st_be : 4'b1111;
               wd_n   = is_st ? st_wd : 32'h0;
               f3_n   = funct3;
               lane_n = addr[1:0];
               rd_n   = 32'h0;
               flt_n  = illegal;
               mis_n  = mis;
               cnt_n  = '0;
               if (illegal || mis) begin
                  state_n = DONE;
               end else begin
                  state_n = BUS;
                  req_n   = 1'b1;
               end
            end
         end
         BUS: begin
            if (bus_ack) begin
               req_n   = 1'b0;
               state_n = RESP;
               if (!bus_we) rd_n = ext;
            end else if (hit_to) begin
               req_n   = 1'b0;
               flt_n   = 1'b1;
               rd_n    = 32'h0;
               state_n = DONE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RESP:    state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         f3_q      <= 3'b000;
         lane_q    <= 2'b00;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_be    <= 4'h0;
         bus_wdata <= 32'h0;
         rdata_out <= 32'h0;
         fault     <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         f3_q      <= f3_n;
         lane_q    <= lane_n;
         bus_req   <= req_n;
         bus_we    <= we_n;
         bus_addr  <= addr_n;
         bus_be    <= be_n;
         bus_wdata <= wd_n;
         rdata_out <= rd_n;
         fault     <= flt_n;
         misalign  <= mis_n;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit (BUS_TIMEOUT = 4).
// Honours MISALIGN_TRAP_EN for the misaligned-word vector.
module tb_mem_access_unit;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdat;
      int          waits;
      logic        bus;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic        we;
      logic [31:0] rdo;
      logic        flt;
      logic        mis;
      int          lat;
      int          nreq;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ack = 1'b0;
   logic        busy, done, fault, misalign;
   logic        bus_req, bus_we;
   logic [31:0] rdata_out, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   always #5 clk = ~clk;

   mem_access_unit #(.BUS_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata_out(rdata_out),
      .fault(fault), .misalign(misalign),
      .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack)
   );

   int nchk = 0;
   int nfail = 0;

   int          nreq, ndone, lat;
   logic        stable, o_we, o_flt, o_mis;
   logic [31:0] o_addr, o_wd, o_rd;
   logic [3:0]  o_be;

   vec_t v [14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t t);
      @(negedge clk);
      start     = 1'b1;
      mem_read  = t.rd;
      mem_write = t.wr;
      funct3    = t.f3;
      addr      = t.addr;
      wdata     = t.wdata;
      bus_rdata = t.rdat;
      @(posedge clk);
      #1;
      start     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      nreq   = 0;
      ndone  = 0;
      lat    = -1;
      stable = 1'b1;
      o_addr = 32'hx; o_wd = 32'hx; o_be = 4'hx; o_we = 1'bx;
      o_rd   = 32'hx; o_flt = 1'bx; o_mis = 1'bx;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (bus_req) begin
            if (nreq == 0) begin
               o_addr = bus_addr;
               o_be   = bus_be;
               o_wd   = bus_wdata;
               o_we   = bus_we;
            end else if (bus_addr !== o_addr || bus_be !== o_be
                      || bus_wdata !== o_wd || bus_we !== o_we) begin
               stable = 1'b0;
            end
            nreq++;
         end
         if (done) begin
            ndone++;
            if (lat < 0) lat = i;
            o_rd  = rdata_out;
            o_flt = fault;
            o_mis = misalign;
         end
         bus_ack = bus_req && (nreq > t.waits);
      end
      bus_ack = 1'b0;
   endtask

   initial begin
      v[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
                1'b1, 32'h100, 4'hF, 32'h0, 1'b0, 32'hFFFF_FF80,
                1'b0, 1'b0, 2, 1};
      v[1]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3,
                1'b1, 32'h200, 4'hC, 32'hABCD_ABCD, 1'b1, 32'h0,
                1'b0, 1'b0, 5, 4};
      v[2]  = '{1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_8001, 1,
                1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0000_8001,
                1'b0, 1'b0, 3, 2};
      v[3]  = '{1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h0000_8001, 0,
                1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 2, 1};
      v[4]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h1122_33A5, 32'h0, 0,
                1'b1, 32'h300, 4'h2, 32'hA5A5_A5A5, 1'b1, 32'h0,
                1'b0, 1'b0, 2, 1};
      v[5]  = '{1'b0, 1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, 32'h0, 2,
                1'b1, 32'h400, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0,
                1'b0, 1'b0, 4, 3};
      v[6]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_F6AB, 0,
                1'b1, 32'h100, 4'hF, 32'h0, 1'b0, 32'h0000_00F6,
                1'b0, 1'b0, 2, 1};
      v[7]  = '{1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h1234_F6AB, 0,
                1'b1, 32'h0, 4'hF, 32'h0, 1'b0, 32'hFFFF_F6AB,
                1'b0, 1'b0, 2, 1};
      v[8]  = '{1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hCAFE_BABE, 2,
                1'b1, 32'h8, 4'hF, 32'h0, 1'b0, 32'hCAFE_BABE,
                1'b0, 1'b0, 4, 3};
      v[9]  = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h5555_5555, 0,
                1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 0, 0};
      v[10] = '{1'b0, 1'b1, 3'b100, 32'h20, 32'h77, 32'h0, 0,
                1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 0, 0};
      v[11] = '{1'b1, 1'b1, 3'b100, 32'h33, 32'h99, 32'hFF00_0000, 0,
                1'b1, 32'h30, 4'hF, 32'h0, 1'b0, 32'h0000_00FF,
                1'b0, 1'b0, 2, 1};
`ifdef MISALIGN_TRAP_EN
      v[12] = '{1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h1357_9BDF, 0,
                1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b1, 0, 0};
`else
      v[12] = '{1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h1357_9BDF, 0,
                1'b1, 32'h4, 4'hF, 32'h0, 1'b0, 32'h1357_9BDF,
                1'b0, 1'b0, 2, 1};
`endif
      v[13] = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_0BAD, 255,
                1'b1, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 4, 4};

      #1 rst = 1'b1;
      #2;
      chk("rst_ctl", {busy, done, fault, misalign, bus_req, bus_we},
          32'h0);
      chk("rst_bus", {bus_be, bus_addr | bus_wdata}, 32'h0);
      chk("rst_rdata", rdata_out, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // start with no direction, then a stray ack, both ignored
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      bus_ack = 1'b1;
      chk("nodir_busy", busy, 1'b0);
      @(posedge clk);
      #1 bus_ack = 1'b0;
      chk("idle_ack", {busy, done, bus_req}, 32'h0);

      for (int i = 0; i < 14; i++) begin
         run(v[i]);
         chk($sformatf("v%0d_nreq", i), nreq, v[i].nreq);
         chk($sformatf("v%0d_lat", i), lat, v[i].lat);
         chk($sformatf("v%0d_ndone", i), ndone, 1);
         chk($sformatf("v%0d_rdata", i), o_rd, v[i].rdo);
         chk($sformatf("v%0d_fault", i), o_flt, v[i].flt);
         chk($sformatf("v%0d_mis", i), o_mis, v[i].mis);
         chk($sformatf("v%0d_held", i), rdata_out, v[i].rdo);
         if (v[i].bus) begin
            chk($sformatf("v%0d_addr", i), o_addr, v[i].baddr);
            chk($sformatf("v%0d_be", i), o_be, v[i].be);
            chk($sformatf("v%0d_we", i), o_we, v[i].we);
            chk($sformatf("v%0d_stable", i), stable, 1'b1);
            if (v[i].we)
               chk($sformatf("v%0d_wd", i), o_wd, v[i].bwd);
         end
      end

      // late ack after the timeout, then an ignored start
      @(negedge clk);
      bus_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus_ack = 1'b0;
      chk("late_ack", {busy, done, bus_req}, 32'h0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("fault_held", fault, 1'b1);

      // reset while the bus request is outstanding
      @(negedge clk);
      start    = 1'b1;
      mem_read = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h80;
      @(posedge clk);
      #1 start = 1'b0;
      mem_read = 1'b0;
      chk("pre_rst_req", bus_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst", {busy, done, bus_req, fault}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus_ack = 1'b1;
      @(posedge clk);
      #1 bus_ack = 1'b0;
      chk("post_rst_ack", {busy, done, bus_req}, 32'h0);
      run(v[0]);
      chk("after_rst_lat", lat, 2);
      chk("after_rst_rd", o_rd, 32'hFFFF_FF80);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
